// File: rtl/csr_ctrl_if.sv
// csr_ctrl_if -- request/response bundle between a core pipeline and csr_ctrl.
//   slave  : the CSR controller side (takes requests and retire pulses,
//            returns ready and the response).
//   master : the requesting side.
// Signals:
//   req_valid_i/req_ready_o    request handshake
//   req_addr_i                 12-bit CSR address
//   req_control_i              operation: PASS / SET / CLEAR (2'b11 acts as PASS)
//   req_op_a_i                 source operand (rs1 value or zimm)
//   req_wr_en_i                0 = read-only access
//   retire_i                   one-cycle pulse per retired instruction
//   resp_valid_o               one-cycle pulse that completes an access
//   resp_rdata_o               CSR value before any update (0 when illegal)
//   resp_illegal_o             access was illegal (qualified by resp_valid_o)
interface csr_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [11:0]      req_addr_i;
    logic [1:0]       req_control_i;
    logic [WIDTH-1:0] req_op_a_i;
    logic             req_wr_en_i;
    logic             retire_i;
    logic             resp_valid_o;
    logic [WIDTH-1:0] resp_rdata_o;
    logic             resp_illegal_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_control_i, req_op_a_i, req_wr_en_i, retire_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_illegal_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_control_i, req_op_a_i, req_wr_en_i, retire_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_illegal_o
    );
endinterface

// File: rtl/csr_ctrl.sv
// csr_ctrl -- machine-mode CSR file with a 3-state access FSM.
// Implements mscratch (0x340), mstatus (0x300, bits 3 and 7 only),
// mcycle (0xB00), minstret (0xB02) and read-only mhartid (0xF14).
// Each access takes IDLE (accept) -> READ (sample old value, decode)
// -> WRITE (respond, commit), i.e. one access every 3 cycles.
// Ports:
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-high reset
//   bus      csr_ctrl_if slave modport (request, retire, response)
module csr_ctrl #(
    parameter int WIDTH   = 32,
    parameter int HART_ID = 0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    csr_ctrl_if.slave    bus
);
    localparam logic [1:0] CSR_SET   = 2'b01;
    localparam logic [1:0] CSR_CLEAR = 2'b10;
    // 2'b00 is PASS; 2'b11 falls through to PASS as well.

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [WIDTH-1:0] MSTATUS_MASK = WIDTH'(8'h88);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    typedef struct packed {
        logic [11:0]      addr;
        logic [1:0]       control;
        logic [WIDTH-1:0] op_a;
        logic             wr_en;
    } req_t;

    state_t           state, state_nxt;
    req_t             req_q;
    logic [WIDTH-1:0] old_q;
    logic             illegal_q;

    logic [WIDTH-1:0] mscratch, mstatus, mcycle, minstret;

    logic [WIDTH-1:0] csr_rdata;
    logic             csr_hit;
    logic             legal;
    logic [WIDTH-1:0] new_val;
    logic             commit;

    // Read mux and legality, driven from the latched request so nothing on
    // the bus after acceptance can disturb the access in flight.
    always_comb begin
        csr_rdata = '0;
        csr_hit   = 1'b1;
        case (req_q.addr)
            A_MSCRATCH: csr_rdata = mscratch;
            A_MSTATUS:  csr_rdata = mstatus;
            A_MCYCLE:   csr_rdata = mcycle;
            A_MINSTRET: csr_rdata = minstret;
            A_MHARTID:  csr_rdata = WIDTH'(HART_ID);
            default:    csr_hit   = 1'b0;
        endcase
        legal = csr_hit && !(req_q.wr_en && req_q.addr == A_MHARTID);
    end

    always_comb begin
        case (req_q.control)
            CSR_SET:   new_val = old_q | req_q.op_a;
            CSR_CLEAR: new_val = old_q & ~req_q.op_a;
            default:   new_val = req_q.op_a;
        endcase
    end

    assign commit = (state == WRITE) && !illegal_q && req_q.wr_en;

    // FSM state register plus per-access holding registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            req_q     <= '0;
            old_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.req_valid_i) begin
                req_q.addr    <= bus.req_addr_i;
                req_q.control <= bus.req_control_i;
                req_q.op_a    <= bus.req_op_a_i;
                req_q.wr_en   <= bus.req_wr_en_i;
            end
            if (state == READ) begin
                // Counters are snapshotted here, so the response shows the
                // READ-cycle value even though they keep moving in WRITE.
                old_q     <= csr_rdata;
                illegal_q <= !legal;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid_i) state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // CSR storage. A committed write beats the counter increment / retire.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mscratch <= '0;
            mstatus  <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (commit && req_q.addr == A_MSCRATCH) mscratch <= new_val;
            if (commit && req_q.addr == A_MSTATUS)  mstatus  <= new_val & MSTATUS_MASK;

            if (commit && req_q.addr == A_MCYCLE) mcycle <= new_val;
            else                                  mcycle <= mcycle + WIDTH'(1);

            if (commit && req_q.addr == A_MINSTRET) minstret <= new_val;
            else if (bus.retire_i)                  minstret <= minstret + WIDTH'(1);
        end
    end

    assign bus.req_ready_o    = (state == IDLE);
    assign bus.resp_valid_o   = (state == WRITE);
    assign bus.resp_rdata_o   = (state == WRITE && !illegal_q) ? old_q : '0;
    assign bus.resp_illegal_o = (state == WRITE) && illegal_q;
endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl -- directed, table-driven bench for csr_ctrl.
// A vector table is applied in order (CSR state carries across entries),
// followed by hand-written sequences for counters, wrap and reset abort.
module tb_csr_ctrl;
    localparam int W   = 32;
    localparam int HID = 5;

    localparam logic [1:0] PASS  = 2'b00;
    localparam logic [1:0] SET   = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_ctrl_if #(.WIDTH(W)) bus ();

    csr_ctrl #(.WIDTH(W), .HART_ID(HID)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [11:0]  addr;
        logic [1:0]   ctrl;
        logic [W-1:0] op;
        logic         wr_en;
        logic [W-1:0] exp_rdata;
        logic         exp_ill;
    } vec_t;

    // One full access. Inputs are scrambled right after acceptance so any
    // dependence on live bus values after the handshake shows up.
    task automatic access(input logic [11:0] addr, input logic [1:0] ctrl,
                          input logic [W-1:0] op, input logic wr_en,
                          input logic retire_in_write,
                          output logic [W-1:0] rdata, output logic ill);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", W'(bus.req_ready_o), W'(1));
        bus.req_valid_i   = 1'b1;
        bus.req_addr_i    = addr;
        bus.req_control_i = ctrl;
        bus.req_op_a_i    = op;
        bus.req_wr_en_i   = wr_en;
        @(negedge clk);                       // READ
        bus.req_valid_i   = 1'b0;
        bus.req_addr_i    = 12'h340;
        bus.req_control_i = ~ctrl;
        bus.req_op_a_i    = ~op;
        bus.req_wr_en_i   = ~wr_en;
        chk("read_no_resp", W'({bus.resp_valid_o, bus.req_ready_o}), W'(0));
        @(negedge clk);                       // WRITE
        chk("resp_latency2", W'(bus.resp_valid_o), W'(1));
        rdata = bus.resp_rdata_o;
        ill   = bus.resp_illegal_o;
        if (retire_in_write) bus.retire_i = 1'b1;
        @(posedge clk);
        #1 bus.retire_i = 1'b0;
        @(negedge clk);                       // back in IDLE
        chk("resp_one_pulse", W'({bus.resp_valid_o, bus.req_ready_o}), W'(1));
    endtask

    task automatic rd(input logic [11:0] addr, output logic [W-1:0] rdata, output logic ill);
        access(addr, SET, '0, 1'b0, 1'b0, rdata, ill);
    endtask

    vec_t vecs[18];
    logic [W-1:0] rdata;
    logic ill;

    initial begin
        bus.req_valid_i   = 1'b0;
        bus.req_addr_i    = '0;
        bus.req_control_i = '0;
        bus.req_op_a_i    = '0;
        bus.req_wr_en_i   = 1'b0;
        bus.retire_i      = 1'b0;

        vecs[0]  = '{12'h340, PASS,  32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
        vecs[1]  = '{12'h340, SET,   32'h0000000F, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{12'h340, SET,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{12'h340, PASS,  32'hFFFFFFFF, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{12'h340, CLEAR, 32'h000000FF, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{12'h340, SET,   32'h0,        1'b0, 32'hFFFFFF00, 1'b0};
        vecs[6]  = '{12'h300, SET,   32'hFFFFFFFF, 1'b1, 32'h0,        1'b0};
        vecs[7]  = '{12'h300, SET,   32'h0,        1'b0, 32'h00000088, 1'b0};
        vecs[8]  = '{12'h300, CLEAR, 32'h00000008, 1'b1, 32'h00000088, 1'b0};
        vecs[9]  = '{12'h300, SET,   32'h0,        1'b0, 32'h00000080, 1'b0};
        vecs[10] = '{12'hF14, PASS,  32'h00001234, 1'b1, 32'h0,        1'b1};
        vecs[11] = '{12'h7C0, SET,   32'h0,        1'b0, 32'h0,        1'b1};
        vecs[12] = '{12'hF14, SET,   32'h0,        1'b0, 32'(HID),     1'b0};
        vecs[13] = '{12'h340, RSVD,  32'h12345678, 1'b1, 32'hFFFFFF00, 1'b0};
        vecs[14] = '{12'h340, SET,   32'h0,        1'b0, 32'h12345678, 1'b0};
        vecs[15] = '{12'hF14, CLEAR, 32'h0,        1'b0, 32'(HID),     1'b0};
        vecs[16] = '{12'h7C0, PASS,  32'h00000055, 1'b1, 32'h0,        1'b1};
        vecs[17] = '{12'h340, SET,   32'h0,        1'b0, 32'h12345678, 1'b0};

        // Reset state, sampled while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_ready",   W'(bus.req_ready_o),    W'(1));
        chk("rst_valid",   W'(bus.resp_valid_o),   W'(0));
        chk("rst_rdata",   bus.resp_rdata_o,       W'(0));
        chk("rst_illegal", W'(bus.resp_illegal_o), W'(0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            access(vecs[i].addr, vecs[i].ctrl, vecs[i].op, vecs[i].wr_en, 1'b0, rdata, ill);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_illegal", i), W'(ill), W'(vecs[i].exp_ill));
        end

        // minstret write wins over a retire pulse in the same WRITE cycle.
        access(12'hB02, PASS, 32'h10, 1'b1, 1'b1, rdata, ill);
        rd(12'hB02, rdata, ill);
        chk("minstret_write_prio", rdata, 32'h10);

        // Three retire pulses then a read.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) bus.retire_i = 1'b1;
            @(negedge clk) bus.retire_i = 1'b0;
        end
        rd(12'hB02, rdata, ill);
        chk("minstret_retire", rdata, 32'h13);

        // mcycle wrap: write all-ones, a few idle cycles, read a small value.
        access(12'hB00, PASS, 32'hFFFFFFFF, 1'b1, 1'b0, rdata, ill);
        repeat (3) @(negedge clk);
        rd(12'hB00, rdata, ill);
        chk("mcycle_wrapped_small", W'(rdata < 32'd16), W'(1));

        // mcycle keeps counting between reads.
        begin
            logic [W-1:0] first;
            first = rdata;
            rd(12'hB00, rdata, ill);
            chk("mcycle_advances", W'(rdata > first), W'(1));
        end

        // Reset during READ aborts the access.
        @(negedge clk);
        bus.req_valid_i   = 1'b1;
        bus.req_addr_i    = 12'h340;
        bus.req_control_i = PASS;
        bus.req_op_a_i    = 32'h5;
        bus.req_wr_en_i   = 1'b1;
        @(negedge clk);                       // READ
        bus.req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_ready", W'(bus.req_ready_o), W'(1));
        chk("abort_no_resp", W'(bus.resp_valid_o), W'(0));
        @(negedge clk);
        chk("abort_no_resp_later", W'(bus.resp_valid_o), W'(0));
        rst = 1'b0;
        rd(12'h340, rdata, ill);
        chk("abort_mscratch_zero", rdata, 32'h0);
        rd(12'hB02, rdata, ill);
        chk("abort_minstret_zero", rdata, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
